// File: rtl/adaptive_phase_sequencer_pkg.sv
// Shared definitions for the adaptive traffic phase sequencer:
// FSM state encoding and default timing constants.
package adaptive_phase_sequencer_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GREEN   = 2'd1;
  localparam logic [1:0] ST_YELLOW  = 2'd2;
  localparam logic [1:0] ST_ALL_RED = 2'd3;

  localparam int DEF_TG_MIN    = 5;
  localparam int DEF_TG_MAX    = 60;
  localparam int DEF_YELLOW_T  = 3;
  localparam int DEF_ALL_RED_T = 1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/adaptive_phase_sequencer_green_time_calc.sv
// Combinational green-time computation: the selected road's count is compared
// against the average count, half the difference is added to the base time, clamped.
module green_time_calc
  import adaptive_phase_sequencer_pkg::*;
#(
  parameter int NUM_ROADS = 4,
  parameter int CNT_W     = 8,
  parameter int TIME_W    = 8,
  parameter int TG_MIN    = DEF_TG_MIN,
  parameter int TG_MAX    = DEF_TG_MAX,
  localparam int RW       = $clog2(NUM_ROADS)
) (
  input  logic [NUM_ROADS*CNT_W-1:0] counts_i,
  input  logic [TIME_W-1:0]          tg_base_i,
  input  logic [RW-1:0]              road_i,
  output logic [TIME_W-1:0]          tg_o
);

  localparam int SUM_W = CNT_W + RW;
  // Wide enough for base + signed half-delta without wrap, plus a guard bit.
  localparam int EXT_W = max_int(TIME_W, CNT_W) + 2;
  localparam logic signed [EXT_W-1:0] MIN_E = EXT_W'(TG_MIN);
  localparam logic signed [EXT_W-1:0] MAX_E = EXT_W'(TG_MAX);

  logic [SUM_W-1:0]        sum_s;
  logic [CNT_W-1:0]        avg_s;
  logic [CNT_W-1:0]        cnt_s;
  logic signed [CNT_W:0]   delta_s;
  logic signed [CNT_W:0]   half_s;
  logic signed [EXT_W-1:0] tg_raw_s;

  // Sum of all approach counts, sized so it cannot overflow.
  always_comb begin
    sum_s = {SUM_W{1'b0}};
    for (int r = 0; r < NUM_ROADS; r++) begin
      sum_s = sum_s + SUM_W'(counts_i[r*CNT_W +: CNT_W]);
    end
  end

  assign avg_s    = CNT_W'(sum_s >> RW);
  assign cnt_s    = counts_i[road_i*CNT_W +: CNT_W];
  assign delta_s  = $signed({1'b0, cnt_s}) - $signed({1'b0, avg_s});
  assign half_s   = delta_s >>> 1'b1;
  assign tg_raw_s = $signed({{(EXT_W-TIME_W){1'b0}}, tg_base_i})
                  + $signed({{(EXT_W-CNT_W-1){half_s[CNT_W]}}, half_s});

  // Clamp into the legal green window.
  always_comb begin
    if (tg_raw_s < MIN_E) begin
      tg_o = TIME_W'(TG_MIN);
    end else if (tg_raw_s > MAX_E) begin
      tg_o = TIME_W'(TG_MAX);
    end else begin
      tg_o = tg_raw_s[TIME_W-1:0];
    end
  end

endmodule

// File: rtl/adaptive_phase_sequencer.sv
// Adaptive traffic-light phase sequencer: round-robin GREEN/YELLOW/ALL_RED cycling
// with per-road green time derived from relative vehicle counts.
module adaptive_phase_sequencer
  import adaptive_phase_sequencer_pkg::*;
#(
  parameter int NUM_ROADS  = 4,
  parameter int CNT_W      = 8,
  parameter int TIME_W     = 8,
  parameter int TG_MIN     = DEF_TG_MIN,
  parameter int TG_MAX     = DEF_TG_MAX,
  parameter int YELLOW_T   = DEF_YELLOW_T,
  parameter int ALL_RED_T  = DEF_ALL_RED_T,
  parameter int SKIP_EMPTY = 1,
  localparam int RW        = $clog2(NUM_ROADS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       tick,
  input  logic                       enable,
  input  logic [NUM_ROADS*CNT_W-1:0] counts,
  input  logic [TIME_W-1:0]          tg_base,
  output logic [NUM_ROADS-1:0]       green,
  output logic [NUM_ROADS-1:0]       yellow,
  output logic [RW-1:0]              active_road,
  output logic [TIME_W-1:0]          tg_current,
  output logic                       phase_done
);

  logic [1:0]           state_q, state_d;
  logic [TIME_W-1:0]    timer_q, timer_d;
  logic [TIME_W-1:0]    tg_q, tg_d;
  logic [RW-1:0]        road_q, road_d;
  logic [NUM_ROADS-1:0] green_q, green_d;
  logic [NUM_ROADS-1:0] yellow_q, yellow_d;
  logic                 done_q, done_d;

  logic [RW-1:0]        next_road_s;
  logic [RW-1:0]        cand_s;
  logic                 found_s;
  logic [RW-1:0]        calc_road_s;
  logic [TIME_W-1:0]    tg_calc_s;
  logic                 expire_s;

  // Round-robin successor; with skipping, the first non-empty road after the current one.
  always_comb begin
    next_road_s = road_q + 1'b1;
    cand_s      = {RW{1'b0}};
    found_s     = 1'b0;
    if (SKIP_EMPTY != 0) begin
      for (int k = 1; k <= NUM_ROADS; k++) begin
        cand_s = road_q + RW'(k);
        if (!found_s && (counts[cand_s*CNT_W +: CNT_W] != {CNT_W{1'b0}})) begin
          next_road_s = cand_s;
          found_s     = 1'b1;
        end else begin
          found_s = found_s;
        end
      end
    end else begin
      found_s = 1'b0;
    end
  end

  assign calc_road_s = (state_q == ST_IDLE) ? {RW{1'b0}} : next_road_s;

  green_time_calc #(
    .NUM_ROADS (NUM_ROADS),
    .CNT_W     (CNT_W),
    .TIME_W    (TIME_W),
    .TG_MIN    (TG_MIN),
    .TG_MAX    (TG_MAX)
  ) u_calc (
    .counts_i  (counts),
    .tg_base_i (tg_base),
    .road_i    (calc_road_s),
    .tg_o      (tg_calc_s)
  );

  // Phase FSM, tick-driven timer and road selection.
  always_comb begin
    expire_s = tick && (timer_q == TIME_W'(1));
    state_d  = state_q;
    road_d   = road_q;
    tg_d     = tg_q;
    done_d   = 1'b0;
    if (tick && (timer_q != {TIME_W{1'b0}})) begin
      timer_d = timer_q - 1'b1;
    end else begin
      timer_d = timer_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_GREEN;
          road_d  = {RW{1'b0}};
          timer_d = tg_calc_s;
          tg_d    = tg_calc_s;
        end else begin
          road_d = {RW{1'b0}};
        end
      end
      ST_GREEN: begin
        if (expire_s) begin
          state_d = ST_YELLOW;
          timer_d = TIME_W'(YELLOW_T);
        end else begin
          state_d = ST_GREEN;
        end
      end
      ST_YELLOW: begin
        if (expire_s) begin
          state_d = ST_ALL_RED;
          timer_d = TIME_W'(ALL_RED_T);
        end else begin
          state_d = ST_YELLOW;
        end
      end
      ST_ALL_RED: begin
        if (expire_s) begin
          done_d = 1'b1;
          if (enable) begin
            state_d = ST_GREEN;
            road_d  = next_road_s;
            timer_d = tg_calc_s;
            tg_d    = tg_calc_s;
          end else begin
            state_d = ST_IDLE;
            road_d  = {RW{1'b0}};
            timer_d = {TIME_W{1'b0}};
          end
        end else begin
          state_d = ST_ALL_RED;
        end
      end
      default: begin
        state_d = ST_IDLE;
        road_d  = {RW{1'b0}};
        timer_d = {TIME_W{1'b0}};
      end
    endcase
  end

  // Lamp outputs decoded from the next state so they register alongside it.
  always_comb begin
    green_d  = {NUM_ROADS{1'b0}};
    yellow_d = {NUM_ROADS{1'b0}};
    case (state_d)
      ST_GREEN:  green_d  = {{(NUM_ROADS-1){1'b0}}, 1'b1} << road_d;
      ST_YELLOW: yellow_d = {{(NUM_ROADS-1){1'b0}}, 1'b1} << road_d;
      default:   green_d  = {NUM_ROADS{1'b0}};
    endcase
  end

  // State and output registers; reset abandons any phase in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      timer_q  <= {TIME_W{1'b0}};
      tg_q     <= {TIME_W{1'b0}};
      road_q   <= {RW{1'b0}};
      green_q  <= {NUM_ROADS{1'b0}};
      yellow_q <= {NUM_ROADS{1'b0}};
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      tg_q     <= tg_d;
      road_q   <= road_d;
      green_q  <= green_d;
      yellow_q <= yellow_d;
      done_q   <= done_d;
    end
  end

  assign green       = green_q;
  assign yellow      = yellow_q;
  assign active_road = road_q;
  assign tg_current  = tg_q;
  assign phase_done  = done_q;

endmodule

// File: tb/tb_adaptive_phase_sequencer.sv
// Self-checking bench for adaptive_phase_sequencer: vector table of count patterns
// with scoreboarded (road, green time) expectations, plus enable-drop and reset sequences.
module tb_adaptive_phase_sequencer;

  localparam int NR = 4;
  localparam int CW = 8;
  localparam int TW = 8;

  typedef struct {
    logic [1:0] road;
    logic [7:0] tg;
  } exp_t;

  typedef struct {
    logic [31:0] cnt;
    logic [7:0]  base;
    bit          ns;
    logic [1:0]  road [4];
    logic [7:0]  tg   [4];
  } vec_t;

  logic clk = 1'b0;
  logic reset, tick, enable;
  logic [NR*CW-1:0] counts;
  logic [TW-1:0] tg_base;

  logic [NR-1:0] green_a, yellow_a, green_b, yellow_b;
  logic [1:0]    road_a, road_b;
  logic [TW-1:0] tg_a, tg_b;
  logic          done_a, done_b;

  logic          sel_ns;
  logic [NR-1:0] m_green, m_yellow;
  logic [1:0]    m_road;
  logic [TW-1:0] m_tg;
  logic          m_done;

  int total = 0;
  int bad = 0;
  int tick_div = 0;
  bit force_tick = 1'b0;

  exp_t q[$];
  exp_t cur;
  logic [NR-1:0] pg = '0, py = '0;
  logic pd = 1'b0;
  int gcnt = 0, ycnt = 0, acnt = 0;
  bit in_ar = 1'b0;
  int n_start = 0, n_done = 0;
  vec_t vecs[5];

  always #5 clk = ~clk;

  adaptive_phase_sequencer dut_skip (
    .clk(clk), .reset(reset), .tick(tick), .enable(enable), .counts(counts),
    .tg_base(tg_base), .green(green_a), .yellow(yellow_a), .active_road(road_a),
    .tg_current(tg_a), .phase_done(done_a)
  );

  adaptive_phase_sequencer #(.SKIP_EMPTY(0)) dut_noskip (
    .clk(clk), .reset(reset), .tick(tick), .enable(enable), .counts(counts),
    .tg_base(tg_base), .green(green_b), .yellow(yellow_b), .active_road(road_b),
    .tg_current(tg_b), .phase_done(done_b)
  );

  assign m_green  = sel_ns ? green_b  : green_a;
  assign m_yellow = sel_ns ? yellow_b : yellow_a;
  assign m_road   = sel_ns ? road_b   : road_a;
  assign m_tg     = sel_ns ? tg_b     : tg_a;
  assign m_done   = sel_ns ? done_b   : done_a;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    if (reset) begin
      chk("rst_green", m_green, 0);
      chk("rst_yellow", m_yellow, 0);
      chk("rst_road", m_road, 0);
      chk("rst_tg", m_tg, 0);
      chk("rst_done", m_done, 0);
      q.delete();
      in_ar = 1'b0;
      gcnt = 0;
      ycnt = 0;
      acnt = 0;
    end else begin
      chk("onehot", ($countones(m_green | m_yellow) <= 1) ? 1 : 0, 1);
      if (pd && m_done) chk("done_pulse_len", 2, 1);
      if (pg != '0 && tick) gcnt++;
      if (py != '0 && tick) ycnt++;
      if (in_ar && tick) acnt++;
      if (m_done) begin
        n_done++;
        chk("allred_ticks", acnt, 1);
        chk("done_in_allred", in_ar, 1);
        in_ar = 1'b0;
      end
      if (pg != '0 && m_green == '0) begin
        chk("green_ticks", gcnt, cur.tg);
        chk("yellow_follows", m_yellow, pg);
      end
      if (py == '0 && m_yellow != '0) ycnt = 0;
      if (py != '0 && m_yellow == '0) begin
        chk("yellow_ticks", ycnt, 3);
        in_ar = 1'b1;
        acnt = 0;
      end
      if (pg == '0 && m_green != '0) begin
        n_start++;
        gcnt = 0;
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_green: road %0d started, none expected", m_road);
        end else begin
          cur = q.pop_front();
          chk("road", m_road, cur.road);
          chk("tg_current", m_tg, cur.tg);
          chk("green_vec", m_green, 32'd1 << cur.road);
        end
      end
    end
    pg = reset ? '0 : m_green;
    py = reset ? '0 : m_yellow;
    pd = reset ? 1'b0 : m_done;
  endtask

  task automatic step();
    tick = force_tick | (tick_div == 2);
    tick_div = (tick_div == 2) ? 0 : tick_div + 1;
    @(posedge clk);
    #1;
    monitor();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic push(input logic [1:0] r, input logic [7:0] t);
    exp_t e;
    e.road = r;
    e.tg = t;
    q.push_back(e);
  endtask

  // Runs n phases, dropping enable once the last one has started.
  task automatic run_phases(input int n);
    int budget = 5000;
    int base = n_done;
    enable = 1'b1;
    while ((n_done - base) < n && budget > 0) begin
      if ((n_done - base) >= n - 1) enable = 1'b0;
      step();
      budget--;
    end
    chk("phases_done", n_done - base, n);
    enable = 1'b0;
  endtask

  task automatic settle_idle();
    repeat (6) step();
    chk("idle_green", m_green, 0);
    chk("idle_yellow", m_yellow, 0);
    chk("idle_road", m_road, 0);
    chk("idle_done", m_done, 0);
    chk("queue_drained", q.size(), 0);
  endtask

  initial begin
    int budget;
    int base;
    reset = 1'b1;
    tick = 1'b0;
    enable = 1'b0;
    counts = '0;
    tg_base = 8'd10;
    sel_ns = 1'b0;

    vecs[0] = '{{8'd15, 8'd20, 8'd22, 8'd43}, 8'd10, 1'b0,
                '{2'd0, 2'd1, 2'd2, 2'd3}, '{8'd19, 8'd8, 8'd7, 8'd5}};
    vecs[1] = '{{8'd0, 8'd0, 8'd0, 8'd255}, 8'd10, 1'b1,
                '{2'd0, 2'd1, 2'd2, 2'd3}, '{8'd60, 8'd5, 8'd5, 8'd5}};
    vecs[2] = '{{8'd10, 8'd0, 8'd0, 8'd10}, 8'd10, 1'b0,
                '{2'd0, 2'd3, 2'd0, 2'd3}, '{8'd12, 8'd12, 8'd12, 8'd12}};
    vecs[3] = '{{8'd0, 8'd0, 8'd0, 8'd0}, 8'd10, 1'b0,
                '{2'd0, 2'd1, 2'd2, 2'd3}, '{8'd10, 8'd10, 8'd10, 8'd10}};
    vecs[4] = '{{8'd8, 8'd8, 8'd8, 8'd8}, 8'd70, 1'b1,
                '{2'd0, 2'd1, 2'd2, 2'd3}, '{8'd60, 8'd60, 8'd60, 8'd60}};

    for (int i = 0; i < 5; i++) begin
      sel_ns = vecs[i].ns;
      counts = vecs[i].cnt;
      tg_base = vecs[i].base;
      do_reset();
      for (int p = 0; p < 4; p++) push(vecs[i].road[p], vecs[i].tg[p]);
      run_phases(4);
      settle_idle();
    end

    // Counts change during road 0 green; enable dropped during road 1 green.
    sel_ns = 1'b0;
    counts = {8'd15, 8'd20, 8'd22, 8'd43};
    tg_base = 8'd10;
    do_reset();
    push(2'd0, 8'd19);
    push(2'd1, 8'd10);
    base = n_done;
    budget = 3000;
    enable = 1'b1;
    while ((n_done - base) < 2 && budget > 0) begin
      if (n_start > 0 && q.size() == 1) counts = {8'd20, 8'd20, 8'd20, 8'd20};
      if ((n_done - base) >= 1) enable = 1'b0;
      step();
      budget--;
    end
    chk("drop_phases", n_done - base, 2);
    enable = 1'b0;
    settle_idle();

    // Reset coinciding with a tick in the middle of road 2 yellow.
    counts = {8'd15, 8'd20, 8'd22, 8'd43};
    do_reset();
    push(2'd0, 8'd19);
    push(2'd1, 8'd8);
    push(2'd2, 8'd7);
    enable = 1'b1;
    budget = 3000;
    while (m_yellow != 4'b0100 && budget > 0) begin
      step();
      budget--;
    end
    chk("reach_yellow2", m_yellow, 4'b0100);
    step();
    force_tick = 1'b1;
    reset = 1'b1;
    step();
    force_tick = 1'b0;
    reset = 1'b0;
    enable = 1'b0;
    repeat (4) step();
    chk("post_rst_green", m_green, 0);
    chk("post_rst_yellow", m_yellow, 0);
    chk("post_rst_road", m_road, 0);
    push(2'd0, 8'd19);
    push(2'd1, 8'd8);
    run_phases(2);
    settle_idle();

    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
